perf_counter_stream_packer: RTL and testbench

Reader side of the performance event counter bank. On a snapshot request it latches every counter value and the overflow map into a shadow register and pulses the counter bank's reset so counting restarts. It then streams a header beat plus the packed snapshot as 64-bit AXI-Stream beats toward the AXI DMA. It sits between the counter bank and the DMA S2MM channel in the continuous monitoring system.

---
 rtl/perf_counter_stream_packer.sv | 101 ++++++++++
 tb/tb_perf_counter_stream_packer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_stream_packer.sv
// perf_counter_stream_packer: snapshots the counter bank, clears it, and streams a header plus packed snapshot over AXI-Stream
module perf_counter_stream_packer #(
    parameter int NUM_COUNTERS  = 115,
    parameter int COUNTER_WIDTH = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COUNTER_WIDTH-1:0] counters [NUM_COUNTERS],
    input  logic [NUM_COUNTERS-1:0]  overflow_map,
    input  logic                     snapshot_req,
    output logic                     counters_rst_n,
    output logic [63:0]              m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     busy,
    output logic [15:0]              dropped_count,
    output logic [31:0]              seq_num
);
    localparam int PACKED_BITS    = NUM_COUNTERS * (COUNTER_WIDTH + 1);
    localparam int NUM_DATA_BEATS = (PACKED_BITS + 63) / 64;
    localparam int SHADOW_BITS    = NUM_DATA_BEATS * 64;
    localparam logic [15:0] LAST_BEAT = 16'(NUM_DATA_BEATS - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            beat_q, beat_d;
    logic [31:0]            seq_q, seq_d;
    logic [15:0]            drop_q, drop_d;
    logic                   crst_q, crst_d;
    logic [SHADOW_BITS-1:0] shadow_q, shadow_d, snap_w;
    logic                   hs;

    always_comb begin
        snap_w = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            snap_w[i*COUNTER_WIDTH +: COUNTER_WIDTH]     = counters[i];
            snap_w[NUM_COUNTERS*COUNTER_WIDTH + i]       = overflow_map[i];
        end
    end

    assign hs = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        seq_d    = seq_q;
        shadow_d = shadow_q;
        crst_d   = 1'b1;
        drop_d   = (snapshot_req && state_q != IDLE && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        case (state_q)
            IDLE: if (snapshot_req) begin
                state_d  = HDR;
                shadow_d = snap_w;
                beat_d   = '0;
                crst_d   = 1'b0;
            end
            HDR: if (hs) begin
                state_d = DATA;
                beat_d  = '0;
            end
            DATA: if (hs) begin
                beat_d = beat_q + 16'd1;
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    seq_d   = seq_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter-bank reset is low during our own reset so both leave reset together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            crst_q   <= 1'b0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            crst_q   <= crst_d;
            shadow_q <= shadow_d;
        end
    end

    assign busy           = state_q != IDLE;
    assign m_axis_tvalid  = busy;
    assign m_axis_tlast   = state_q == DATA && beat_q == LAST_BEAT;
    assign m_axis_tdata   = state_q == HDR  ? {seq_q, 16'(NUM_DATA_BEATS), 16'hC0DE} :
                            state_q == DATA ? shadow_q[beat_q*64 +: 64] : 64'd0;
    assign counters_rst_n = crst_q;
    assign dropped_count  = drop_q;
    assign seq_num        = seq_q;
endmodule

// File: tb/tb_perf_counter_stream_packer.sv
// tb_perf_counter_stream_packer: randomized self-checking bench against a bit-level packing model
module tb_perf_counter_stream_packer;
    localparam int N  = 115;
    localparam int W  = 7;
    localparam int PB = N * (W + 1);
    localparam int NB = (PB + 63) / 64;

    logic        clk = 0, rst_n = 0, snapshot_req = 0, m_axis_tready = 0;
    logic [W-1:0] cnt [N];
    logic [N-1:0] ovf;
    logic        counters_rst_n, m_axis_tvalid, m_axis_tlast, busy;
    logic [63:0] m_axis_tdata;
    logic [15:0] dropped_count;
    logic [31:0] seq_num;

    int checks = 0, errors = 0;
    int mseq = 0, mdrop = 0;

    perf_counter_stream_packer #(.NUM_COUNTERS(N), .COUNTER_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .counters(cnt), .overflow_map(ovf),
        .snapshot_req(snapshot_req), .counters_rst_n(counters_rst_n),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .dropped_count(dropped_count), .seq_num(seq_num)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_beat(int k);
        logic [63:0] r = '0;
        for (int b = 0; b < 64; b++) begin
            int idx = k * 64 + b;
            if (idx < N * W) r[b] = cnt[idx / W][idx % W];
            else if (idx < PB) r[b] = ovf[idx - N * W];
        end
        return r;
    endfunction

    task automatic set_inputs(input int kind);
        for (int i = 0; i < N; i++) cnt[i] = kind == 0 ? '0 : kind == 1 ? '1 : W'($urandom);
        ovf = kind == 0 ? '0 : kind == 1 ? '1 : {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic apply_reset();
        rst_n = 0; snapshot_req = 0; m_axis_tready = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        mseq = 0; mdrop = 0;
    endtask

    task automatic do_packet(input int mode, input int drop1, input int drop2, input bit scramble,
                             output logic [63:0] got [$]);
        logic [63:0] exp_q [$];
        logic        lasts [$];
        logic [63:0] hold_d;
        logic        hold_l, stalled, done;
        int          c;
        exp_q.push_back({32'(mseq), 16'(NB), 16'hC0DE});
        for (int k = 0; k < NB; k++) exp_q.push_back(model_beat(k));
        got = {};
        stalled = 0; done = 0; c = 0;
        hold_d = '0; hold_l = 0;
        snapshot_req = 1;
        @(negedge clk);
        while (!done && c < 300) begin
            c++;
            m_axis_tready = mode == 0 ? 1'b1 : mode == 1 ? (((c - 1) % 4 == 0) || ((c - 1) % 4 == 3)) : 1'($urandom_range(0, 1));
            snapshot_req = (c == drop1 || c == drop2);
            if (scramble) set_inputs(2);
            if (c == 1) begin
                chk("clear_pulse_low", 64'(counters_rst_n), 64'd0);
                chk("busy_after_capture", 64'(busy), 64'd1);
            end
            if (c == 2) chk("clear_pulse_high", 64'(counters_rst_n), 64'd1);
            if (stalled) begin
                chk("stall_tdata", m_axis_tdata, hold_d);
                chk("stall_tlast", 64'(m_axis_tlast), 64'(hold_l));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got.push_back(m_axis_tdata);
                lasts.push_back(m_axis_tlast);
                if (m_axis_tlast || got.size() > NB) done = 1;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            hold_d = m_axis_tdata; hold_l = m_axis_tlast;
            @(negedge clk);
        end
        snapshot_req = 0;
        m_axis_tready = 0;
        if (!done) chk("packet_timeout", 64'(c), 64'(-1));
        chk("beat_count", 64'(got.size()), 64'(NB + 1));
        for (int i = 0; i < got.size() && i <= NB; i++) begin
            chk($sformatf("beat%0d", i), got[i], exp_q[i]);
            chk($sformatf("tlast%0d", i), 64'(lasts[i]), 64'(i == NB));
        end
        chk("busy_end", 64'(busy), 64'd0);
        chk("tvalid_end", 64'(m_axis_tvalid), 64'd0);
        mseq++;
        chk("seq_num", 64'(seq_num), 64'(mseq));
        chk("dropped_count", 64'(dropped_count), 64'(mdrop));
    endtask

    task automatic test_reset();
        set_inputs(0);
        rst_n = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_crst", 64'(counters_rst_n), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_seq", 64'(seq_num), 64'd0);
        chk("rst_drop", 64'(dropped_count), 64'd0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_release_crst", 64'(counters_rst_n), 64'd1);
        mseq = 0; mdrop = 0;
    endtask

    task automatic test_zero();
        logic [63:0] g [$];
        set_inputs(0);
        do_packet(0, 0, 0, 0, g);
        if (g.size() > 0) chk("zero_header", g[0], 64'h0000_0000_000F_C0DE);
    endtask

    task automatic test_counters();
        logic [63:0] g [$];
        set_inputs(0);
        cnt[0] = 7'h7F; cnt[1] = 7'h01;
        do_packet(0, 0, 0, 0, g);
        if (g.size() > 1) chk("cnt_beat0", g[1], 64'h0000_0000_0000_00FF);
    endtask

    task automatic test_overflow();
        logic [63:0] g [$];
        set_inputs(0);
        ovf[0] = 1'b1;
        do_packet(0, 0, 0, 0, g);
        if (g.size() > 13) chk("ovf_beat12", g[13], 64'h0000_0020_0000_0000);
        set_inputs(1);
        do_packet(0, 0, 0, 0, g);
        if (g.size() > 15) chk("max_beat14_pad", {40'd0, g[15][23:0]} ^ g[15], 64'd0);
    endtask

    task automatic test_backpressure();
        logic [63:0] g [$];
        set_inputs(2);
        do_packet(1, 0, 0, 1, g);
        for (int r = 0; r < 3; r++) begin
            set_inputs(2);
            do_packet(2, 0, 0, 1, g);
        end
    endtask

    task automatic test_drop();
        logic [63:0] g [$];
        apply_reset();
        set_inputs(2);
        mdrop = 2;
        do_packet(0, 5, 16, 0, g);
        set_inputs(2);
        do_packet(0, 0, 0, 0, g);
        if (g.size() > 0) chk("drop_next_hdr_seq", 64'(g[0][63:32]), 64'd1);
    endtask

    task automatic test_reset_mid();
        logic [63:0] g [$];
        set_inputs(2);
        snapshot_req = 1;
        m_axis_tready = 1;
        @(negedge clk);
        snapshot_req = 0;
        repeat (8) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_crst", 64'(counters_rst_n), 64'd0);
        chk("midrst_seq", 64'(seq_num), 64'd0);
        chk("midrst_drop", 64'(dropped_count), 64'd0);
        chk("midrst_tdata", m_axis_tdata, 64'd0);
        @(negedge clk);
        m_axis_tready = 0;
        mseq = 0; mdrop = 0;
        set_inputs(2);
        do_packet(0, 0, 0, 0, g);
        if (g.size() > 0) chk("midrst_hdr_seq", 64'(g[0][63:32]), 64'd0);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_counters();
        test_overflow();
        test_backpressure();
        test_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
